// File: rtl/rv32i_types.sv
// Shared rv32i types used by the fetch front end.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        REQ,
        FLUSH,
        HOLD
    } fetch_state_t;

    // One presented or buffered instruction.
    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_pkt_t;

    // Redirect targets are word aligned; low bits are dropped.
    function automatic rv32i_word align_word(input rv32i_word addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem read, one-entry skid for
// decode back-pressure, flush of in-flight fetches on control-flow redirects.
module fetch_ctrl
    import rv32i_types::*;
#(
    parameter rv32i_word   RESET_PC = 32'h0000_0060,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic      clk,
    input  logic      rst,
    output logic      imem_read,
    output rv32i_word imem_address,
    input  logic      imem_resp,
    input  rv32i_word imem_rdata,
    input  logic      stall,
    input  logic      redirect_valid,
    input  rv32i_word redirect_pc,
    output logic      if_valid,
    output rv32i_word if_pc,
    output rv32i_word if_instr
);

    localparam rv32i_word Step = rv32i_word'(PC_STEP);

    fetch_state_t state_q, state_d;
    rv32i_word    fetch_pc_q, fetch_pc_d;
    rv32i_word    req_addr_q, req_addr_d;
    fetch_pkt_t   out_q, out_d;
    logic         out_valid_q, out_valid_d;
    fetch_pkt_t   skid_q, skid_d;
    logic         skid_valid_q, skid_valid_d;

    rv32i_word target;
    rv32i_word req_next;
    logic      slot_consumed;
    logic      slot_free;

    assign target        = align_word(redirect_pc);
    assign req_next      = req_addr_q + Step;
    assign slot_consumed = out_valid_q && !stall;
    assign slot_free     = !out_valid_q || !stall;

    // Memory side: request is live in REQ/FLUSH, suppressed while reset is held.
    assign imem_read    = rst && (state_q != HOLD);
    assign imem_address = req_addr_q;

    // Decode sees registers only; no path from imem_rdata.
    assign if_valid = out_valid_q;
    assign if_pc    = out_q.pc;
    assign if_instr = out_q.instr;

    // Next-state, PC tracking, output-slot and skid updates; redirect beats stall.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (slot_consumed) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    fetch_pc_d  = target;
                    if (imem_resp) begin
                        // Response is dropped; the new target can go out right away.
                        req_addr_d = target;
                    end else begin
                        // Request to the stale address must still complete first.
                        state_d = FLUSH;
                    end
                end else if (imem_resp) begin
                    fetch_pc_d = req_next;
                    if (slot_free) begin
                        out_d       = '{pc: req_addr_q, instr: imem_rdata};
                        out_valid_d = 1'b1;
                        req_addr_d  = req_next;
                    end else begin
                        skid_d       = '{pc: req_addr_q, instr: imem_rdata};
                        skid_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    fetch_pc_d  = target;
                    out_valid_d = 1'b0;
                end
                if (imem_resp) begin
                    req_addr_d = redirect_valid ? target : fetch_pc_q;
                    state_d    = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                    fetch_pc_d   = target;
                    req_addr_d   = target;
                    state_d      = REQ;
                end else if (!stall) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                    req_addr_d   = fetch_pc_q;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= REQ;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= RESET_PC;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small latency-programmable memory model.
module tb_fetch_ctrl;
    import rv32i_types::*;

    logic      clk;
    logic      rst;
    logic      imem_read;
    rv32i_word imem_address;
    logic      imem_resp;
    rv32i_word imem_rdata;
    logic      stall;
    logic      redirect_valid;
    rv32i_word redirect_pc;
    logic      if_valid;
    rv32i_word if_pc;
    rv32i_word if_instr;

    int n_tests;
    int n_fail;

    // Memory model state
    logic      mem_en;
    logic      pending;
    int        wait_cnt;
    int        lat;
    rv32i_word pend_addr;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a rising edge: retire last response, advance latency, accept new read.
    task automatic mem_update();
        if (!mem_en) return;
        imem_resp = 1'b0;
        if (pending) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = {16'hC0DE, pend_addr[15:0]};
                pending    = 1'b0;
            end
        end else if (imem_read) begin
            pending   = 1'b1;
            pend_addr = imem_address;
            wait_cnt  = lat;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mem_update();
    endtask

    task automatic hold_reset();
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_resp      = 1'b0;
        imem_rdata     = '0;
        pending        = 1'b0;
        wait_cnt       = 0;
        mem_en         = 1'b1;
        lat            = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b1;
        #1;
        mem_update();
    endtask

    task automatic do_reset();
        hold_reset();
        release_reset();
    endtask

    task automatic test_reset();
        hold_reset();
        n_tests++;
        if (imem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: got %0b want 0", imem_read);
        end
        n_tests++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %0b want 0", if_valid);
        end
        n_tests++;
        if (if_pc !== 32'h0 || if_instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pkt: got pc %h instr %h want 0/0", if_pc, if_instr);
        end
        release_reset();
        n_tests++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60) begin
            n_fail++;
            $display("FAIL reset_first_req: got read %0b addr %h want 1/00000060",
                     imem_read, imem_address);
        end
    endtask

    // Stall low, latency 1: one instruction every two cycles in PC order.
    task automatic test_stream();
        rv32i_word ea [7] = '{32'h60, 32'h60, 32'h64, 32'h64, 32'h68, 32'h68, 32'h6C};
        bit        ev [7] = '{0, 0, 1, 0, 1, 0, 1};
        rv32i_word ep [7] = '{0, 0, 32'h60, 0, 32'h64, 0, 32'h68};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (imem_read !== 1'b1 || imem_address !== ea[i]) begin
                n_fail++;
                $display("FAIL stream_req c%0d: got %0b/%h want 1/%h", i, imem_read,
                         imem_address, ea[i]);
            end
            n_tests++;
            if (if_valid !== ev[i]) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: got %0b want %0b", i, if_valid, ev[i]);
            end
            if (ev[i]) begin
                n_tests++;
                if (if_pc !== ep[i] || if_instr !== {16'hC0DE, ep[i][15:0]}) begin
                    n_fail++;
                    $display("FAIL stream_pkt c%0d: got %h/%h want pc %h", i, if_pc,
                             if_instr, ep[i]);
                end
            end
            step();
        end
    endtask

    // Stall held 5 cycles: 0x60 held in output, 0x64 parked in skid, no reads in HOLD.
    task automatic test_stall_skid();
        bit        er [9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
        rv32i_word ea [9] = '{32'h60, 32'h60, 32'h64, 32'h64, 0, 0, 32'h68, 32'h68, 32'h6C};
        bit        ev [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 1};
        rv32i_word ep [9] = '{0, 0, 32'h60, 32'h60, 32'h60, 32'h60, 32'h64, 0, 32'h68};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            stall = (i < 5);
            n_tests++;
            if (imem_read !== er[i] || (er[i] && imem_address !== ea[i])) begin
                n_fail++;
                $display("FAIL stall_req c%0d: got %0b/%h want %0b/%h", i, imem_read,
                         imem_address, er[i], ea[i]);
            end
            n_tests++;
            if (if_valid !== ev[i] || (ev[i] && if_pc !== ep[i])) begin
                n_fail++;
                $display("FAIL stall_out c%0d: got %0b/%h want %0b/%h", i, if_valid, if_pc,
                         ev[i], ep[i]);
            end
            if (ev[i]) begin
                n_tests++;
                if (if_instr !== {16'hC0DE, ep[i][15:0]}) begin
                    n_fail++;
                    $display("FAIL stall_instr c%0d: got %h want pc %h", i, if_instr, ep[i]);
                end
            end
            step();
        end
        stall = 1'b0;
    endtask

    // Redirect while a 3-cycle fetch to 0x70 is outstanding.
    task automatic test_redirect_flush();
        rv32i_word ea [9] = '{32'h60, 32'h60, 32'h70, 32'h70, 32'h70, 32'h70,
                              32'h200, 32'h200, 32'h204};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            redirect_valid = (i == 0) || (i == 3);
            redirect_pc    = (i == 0) ? 32'h70 : 32'h200;
            if (i == 1) lat = 3;
            if (i == 5) lat = 1;
            n_tests++;
            if (imem_read !== 1'b1 || imem_address !== ea[i]) begin
                n_fail++;
                $display("FAIL flush_req c%0d: got %0b/%h want 1/%h", i, imem_read,
                         imem_address, ea[i]);
            end
            n_tests++;
            if (if_valid !== (i == 8)) begin
                n_fail++;
                $display("FAIL flush_valid c%0d: got %0b want %0b", i, if_valid, (i == 8));
            end
            step();
        end
        redirect_valid = 1'b0;
        // Step index 9: the 0x200 packet has been consumed; check it was the one shown at c8.
    endtask

    task automatic test_flush_pkt();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'hC0DE_0200) begin
            n_fail++;
            $display("FAIL flush_pkt: got %0b/%h/%h want 1/00000200/c0de0200", if_valid,
                     if_pc, if_instr);
        end
    endtask

    // Redirect coincident with a response while output is held under stall.
    task automatic test_redirect_resp();
        rv32i_word ea [7] = '{32'h60, 32'h60, 32'h64, 32'h64, 32'h300, 32'h300, 32'h304};
        bit        ev [7] = '{0, 0, 1, 1, 0, 0, 1};
        rv32i_word ep [7] = '{0, 0, 32'h60, 32'h60, 0, 0, 32'h300};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            stall          = (i == 2) || (i == 3);
            redirect_valid = (i == 3);
            redirect_pc    = 32'h300;
            n_tests++;
            if (imem_read !== 1'b1 || imem_address !== ea[i]) begin
                n_fail++;
                $display("FAIL rdresp_req c%0d: got %0b/%h want 1/%h", i, imem_read,
                         imem_address, ea[i]);
            end
            n_tests++;
            if (if_valid !== ev[i] || (ev[i] && if_pc !== ep[i])) begin
                n_fail++;
                $display("FAIL rdresp_out c%0d: got %0b/%h want %0b/%h", i, if_valid, if_pc,
                         ev[i], ep[i]);
            end
            step();
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

    // Redirect in HOLD with both buffers full and stall high; 0x203 aligns to 0x200.
    task automatic test_hold_redirect();
        bit        er [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        rv32i_word ea [9] = '{32'h60, 32'h60, 32'h64, 32'h64, 0, 32'h200, 32'h200,
                              32'h204, 32'h204};
        bit        ev [9] = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
        rv32i_word ep [9] = '{0, 0, 32'h60, 32'h60, 32'h60, 0, 0, 32'h200, 32'h200};
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            redirect_valid = (i == 4);
            redirect_pc    = 32'h203;
            n_tests++;
            if (imem_read !== er[i] || (er[i] && imem_address !== ea[i])) begin
                n_fail++;
                $display("FAIL hold_req c%0d: got %0b/%h want %0b/%h", i, imem_read,
                         imem_address, er[i], ea[i]);
            end
            n_tests++;
            if (if_valid !== ev[i] || (ev[i] && if_pc !== ep[i])) begin
                n_fail++;
                $display("FAIL hold_out c%0d: got %0b/%h want %0b/%h", i, if_valid, if_pc,
                         ev[i], ep[i]);
            end
            step();
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;
    endtask

    // PC arithmetic wraps at the top of the address space.
    task automatic test_wrap();
        rv32i_word ea [5] = '{32'h60, 32'h60, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            redirect_valid = (i == 0);
            redirect_pc    = 32'hFFFF_FFFC;
            n_tests++;
            if (imem_read !== 1'b1 || imem_address !== ea[i]) begin
                n_fail++;
                $display("FAIL wrap_req c%0d: got %0b/%h want 1/%h", i, imem_read,
                         imem_address, ea[i]);
            end
            if (i < 4) step();
        end
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'hC0DE_FFFC) begin
            n_fail++;
            $display("FAIL wrap_pkt: got %0b/%h/%h want 1/fffffffc/c0defffc", if_valid,
                     if_pc, if_instr);
        end
        redirect_valid = 1'b0;
    endtask

    // Reset asserted mid-request: immediate clear, stray response ignored.
    task automatic test_async_reset();
        do_reset();
        step();
        step();
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h60) begin
            n_fail++;
            $display("FAIL areset_pre: got %0b/%h want 1/00000060", if_valid, if_pc);
        end
        mem_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_read !== 1'b0)
        begin
            n_fail++;
            $display("FAIL areset_now: got v%0b pc %h instr %h read %0b want all 0", if_valid,
                     if_pc, if_instr, imem_read);
        end
        imem_resp  = 1'b1;
        imem_rdata = 32'hBADB_AD00;
        step();
        n_tests++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_late_resp: got v%0b instr %h read %0b want 0/0/0", if_valid,
                     if_instr, imem_read);
        end
        imem_resp = 1'b0;
        pending   = 1'b0;
        mem_en    = 1'b1;
        release_reset();
        n_tests++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_restart: got %0b/%h v%0b want 1/00000060 v0", imem_read,
                     imem_address, if_valid);
        end
        step();
        step();
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 32'h60 || if_instr !== 32'hC0DE_0060) begin
            n_fail++;
            $display("FAIL areset_first_pkt: got %0b/%h/%h want 1/00000060/c0de0060",
                     if_valid, if_pc, if_instr);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_redirect_flush();
        test_flush_pkt();
        test_redirect_resp();
        test_hold_redirect();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
